// File: rtl/down_counter_mod_if.sv
// Control and status bundle for one down_counter_mod digit.
// master drives count/load controls; slave is the counter itself.
interface down_counter_mod_if #(
  parameter int unsigned WIDTH = 4
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] q_bus;
  logic             zero;
  logic             borrow_out;
  logic             done;

  modport master (
    output enable,
    output load,
    output load_value,
    input  q_bus,
    input  zero,
    input  borrow_out,
    input  done
  );

  modport slave (
    input  enable,
    input  load,
    input  load_value,
    output q_bus,
    output zero,
    output borrow_out,
    output done
  );
endinterface

// File: rtl/down_counter_mod.sv
// Modulo-N down counter for cascaded timer digits: wraps with borrow (WRAP=1)
// or stops at zero with a one-cycle done pulse (WRAP=0).
module down_counter_mod #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10,
  parameter bit          WRAP    = 1'b1
) (
  input logic              clock,
  input logic              reset,
  down_counter_mod_if.slave bus
);

  localparam logic [WIDTH-1:0] ModMax = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] load_clamped;
  logic             is_zero;
  logic             is_one;

  always_comb begin
    is_zero = (q_q == '0);
    is_one  = (q_q == One);
    // Out-of-range presets saturate so the count never leaves 0..MODULUS-1.
    if (32'(bus.load_value) >= MODULUS) begin
      load_clamped = ModMax;
    end else begin
      load_clamped = bus.load_value;
    end
  end

  always_comb begin
    q_d    = q_q;
    done_d = 1'b0;
    if (bus.load) begin
      q_d = load_clamped;
    end else if (bus.enable) begin
      if (!is_zero) begin
        q_d    = q_q - One;
        done_d = is_one;
      end else if (WRAP) begin
        q_d = ModMax;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      done_q <= done_d;
    end
  end

  // Borrow is gated by reset so a held-in-reset digit never advances its neighbour.
  always_comb begin
    bus.q_bus      = q_q;
    bus.zero       = is_zero;
    bus.done       = done_q;
    bus.borrow_out = bus.enable & is_zero & ~bus.load & WRAP & reset;
  end

endmodule

// File: tb/tb_down_counter_mod.sv
// Self-checking bench for down_counter_mod: wrap, one-shot, clamp, cascade
// and degenerate-modulus instances checked through a scoreboard queue.
module tb_down_counter_mod;

  logic clock;
  logic rst_n;

  down_counter_mod_if #(.WIDTH(4)) m_if ();
  down_counter_mod_if #(.WIDTH(6)) o_if ();
  down_counter_mod_if #(.WIDTH(4)) lo_if ();
  down_counter_mod_if #(.WIDTH(4)) hi_if ();
  down_counter_mod_if #(.WIDTH(1)) d_if ();

  down_counter_mod #(.WIDTH(4), .MODULUS(10), .WRAP(1'b1)) u_main (
    .clock (clock),
    .reset (rst_n),
    .bus   (m_if)
  );

  down_counter_mod #(.WIDTH(6), .MODULUS(60), .WRAP(1'b0)) u_oneshot (
    .clock (clock),
    .reset (rst_n),
    .bus   (o_if)
  );

  down_counter_mod #(.WIDTH(4), .MODULUS(10), .WRAP(1'b1)) u_lo (
    .clock (clock),
    .reset (rst_n),
    .bus   (lo_if)
  );

  down_counter_mod #(.WIDTH(4), .MODULUS(10), .WRAP(1'b1)) u_hi (
    .clock (clock),
    .reset (rst_n),
    .bus   (hi_if)
  );

  down_counter_mod #(.WIDTH(1), .MODULUS(2), .WRAP(1'b1)) u_deg (
    .clock (clock),
    .reset (rst_n),
    .bus   (d_if)
  );

  assign hi_if.enable = lo_if.borrow_out;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    string       tag;
    int unsigned q;
    bit          z;
    bit          b;
    bit          d;
  } exp_t;

  exp_t sb[$];

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int unsigned q, input bit z, input bit b,
                          input bit d);
    exp_t e;
    e.tag = tag;
    e.q   = q;
    e.z   = z;
    e.b   = b;
    e.d   = d;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input int unsigned q, input logic z, input logic b, input logic d);
    exp_t e;
    if (sb.size() == 0) begin
      check_val("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check_val({e.tag, ".q"}, q, e.q);
      check_val({e.tag, ".zero"}, 32'(z), 32'(e.z));
      check_val({e.tag, ".borrow"}, 32'(b), 32'(e.b));
      check_val({e.tag, ".done"}, 32'(d), 32'(e.d));
    end
  endtask

  // Each step: drive inputs, compare the cycle they are applied in, then clock.
  task automatic step_m(input bit en, input bit ld, input int unsigned lv, input string tag,
                        input int unsigned eq, input bit ez, input bit eb, input bit ed);
    m_if.enable     = en;
    m_if.load       = ld;
    m_if.load_value = 4'(lv);
    push_exp(tag, eq, ez, eb, ed);
    #1;
    pop_cmp(32'(m_if.q_bus), m_if.zero, m_if.borrow_out, m_if.done);
    @(posedge clock);
    #1;
  endtask

  task automatic step_o(input bit en, input bit ld, input int unsigned lv, input string tag,
                        input int unsigned eq, input bit ez, input bit eb, input bit ed);
    o_if.enable     = en;
    o_if.load       = ld;
    o_if.load_value = 6'(lv);
    push_exp(tag, eq, ez, eb, ed);
    #1;
    pop_cmp(32'(o_if.q_bus), o_if.zero, o_if.borrow_out, o_if.done);
    @(posedge clock);
    #1;
  endtask

  task automatic step_d(input bit en, input string tag, input int unsigned eq, input bit ez,
                        input bit eb, input bit ed);
    d_if.enable = en;
    push_exp(tag, eq, ez, eb, ed);
    #1;
    pop_cmp(32'(d_if.q_bus), d_if.zero, d_if.borrow_out, d_if.done);
    @(posedge clock);
    #1;
  endtask

  // Cascade observation: two-digit value, low zero, low borrow, high done.
  task automatic step_c(input bit en, input bit ld, input int unsigned lo_v,
                        input int unsigned hi_v, input string tag, input int unsigned ev,
                        input bit ez, input bit eb, input bit ed);
    lo_if.enable     = en;
    lo_if.load       = ld;
    lo_if.load_value = 4'(lo_v);
    hi_if.load       = ld;
    hi_if.load_value = 4'(hi_v);
    push_exp(tag, ev, ez, eb, ed);
    #1;
    pop_cmp(32'(hi_if.q_bus) * 10 + 32'(lo_if.q_bus), lo_if.zero, lo_if.borrow_out,
            hi_if.done);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    m_if.enable = 1'b0; m_if.load = 1'b0; m_if.load_value = '0;
    o_if.enable = 1'b0; o_if.load = 1'b0; o_if.load_value = '0;
    lo_if.enable = 1'b0; lo_if.load = 1'b0; lo_if.load_value = '0;
    hi_if.load = 1'b0; hi_if.load_value = '0;
    d_if.enable = 1'b0; d_if.load = 1'b0; d_if.load_value = '0;
    #1;

    // Held in reset: enable must be ignored, borrow stays low.
    step_m(1, 0, 0, "rst0", 0, 1, 0, 0);
    step_m(1, 0, 0, "rst1", 0, 1, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step_m(0, 0, 0, "rel_hold", 0, 1, 0, 0);

    // Wrap with borrow: 2,1,0,9,8.
    step_m(0, 1, 2, "ld2", 0, 1, 0, 0);
    step_m(1, 0, 0, "w2", 2, 0, 0, 0);
    step_m(1, 0, 0, "w1", 1, 0, 0, 0);
    step_m(1, 0, 0, "w0", 0, 1, 1, 1);
    step_m(1, 0, 0, "w9", 9, 0, 0, 0);
    step_m(0, 0, 0, "w8", 8, 0, 0, 0);

    // Load priority and clamp.
    step_m(0, 1, 5, "ld5", 8, 0, 0, 0);
    step_m(1, 1, 12, "ld12_en", 5, 0, 0, 0);
    step_m(0, 1, 0, "clamp12", 9, 0, 0, 0);
    step_m(1, 1, 10, "ld_at0", 0, 1, 0, 0);
    step_m(0, 1, 9, "clamp10", 9, 0, 0, 0);
    step_m(0, 0, 0, "ld9", 9, 0, 0, 0);

    // Asynchronous reset mid-count.
    step_m(0, 1, 7, "ld7", 9, 0, 0, 0);
    step_m(1, 0, 0, "c7", 7, 0, 0, 0);
    m_if.enable = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    push_exp("async_rst", 0, 1, 0, 0);
    pop_cmp(32'(m_if.q_bus), m_if.zero, m_if.borrow_out, m_if.done);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    step_m(0, 0, 0, "post_rst", 0, 1, 0, 0);

    // Reset clears a live done pulse without a clock edge.
    step_m(0, 1, 1, "ld1", 0, 1, 0, 0);
    step_m(1, 0, 0, "c1", 1, 0, 0, 0);
    m_if.enable = 1'b0;
    #1;
    push_exp("done_pulse", 0, 1, 0, 1);
    pop_cmp(32'(m_if.q_bus), m_if.zero, m_if.borrow_out, m_if.done);
    #1;
    rst_n = 1'b0;
    #1;
    push_exp("done_rst", 0, 1, 0, 0);
    pop_cmp(32'(m_if.q_bus), m_if.zero, m_if.borrow_out, m_if.done);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    step_m(0, 0, 0, "done_rel", 0, 1, 0, 0);

    // One-shot: 3,2,1,0,0,0 with a single done and no borrow.
    step_o(0, 1, 3, "o_ld3", 0, 1, 0, 0);
    step_o(1, 0, 0, "o3", 3, 0, 0, 0);
    step_o(1, 0, 0, "o2", 2, 0, 0, 0);
    step_o(1, 0, 0, "o1", 1, 0, 0, 0);
    step_o(1, 0, 0, "o0a", 0, 1, 0, 1);
    step_o(1, 0, 0, "o0b", 0, 1, 0, 0);
    step_o(1, 0, 0, "o0c", 0, 1, 0, 0);
    step_o(0, 1, 63, "o_hold", 0, 1, 0, 0);
    step_o(0, 0, 0, "o_clamp", 59, 0, 0, 0);

    // Degenerate modulus 2: toggles, borrow whenever at 0.
    step_d(1, "d0a", 0, 1, 1, 0);
    step_d(1, "d1a", 1, 0, 0, 0);
    step_d(1, "d0b", 0, 1, 1, 1);
    step_d(1, "d1b", 1, 0, 0, 0);
    step_d(1, "d0c", 0, 1, 1, 1);
    step_d(0, "d1c", 1, 0, 0, 0);

    // Cascade: 10 counts down to 00, then wraps to 99.
    step_c(0, 1, 0, 1, "c_ld", 0, 1, 0, 0);
    for (int k = 0; k <= 10; k++) begin
      int unsigned v;
      v = 10 - k;
      step_c(1, 0, 0, 0, "casc", v, (v % 10) == 0, (v % 10) == 0, k == 1);
    end
    step_c(0, 0, 0, 0, "c_99", 99, 0, 0, 0);

    check_val("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/down_counter_mod.md
# down_counter_mod

Parametrised modulo-N down counter for the irrigation timer, generalising the fixed 2-bit count-down-from-3 stage. It counts from a loadable value toward zero, either wrapping to MODULUS-1 with a borrow for cascading timer digits (seconds/minutes/hours) or stopping at zero in one-shot mode with a completion pulse. It sits in the timer path between the valve-duration setting logic and the valve control FSM.

## Interface

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 10, count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH.
- WRAP, 1, 1 = cyclic (0 -> MODULUS-1 with borrow), 0 = one-shot (hold at 0).

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- enable, input, 1, count-down strobe. Cascade input from the lower digit's borrow_out.
- load, input, 1, synchronous load of load_value.
- load_value, input, WIDTH, preset value.
- q_bus, output, WIDTH, current count (registered).
- zero, output, 1, q_bus == 0 (combinational from the register).
- borrow_out, output, 1, combinational cascade strobe to the next digit.
- done, output, 1, registered one-cycle completion pulse.

## Operation

- Reset (reset = 0, asynchronous): q_bus = 0, done = 0. Consequently zero = 1 and borrow_out = 0 (enable is ignored while in reset).
- Priority at each rising edge: reset > load > enable > hold.
- Load:
  - q_bus <= load_value. If load_value >= MODULUS, it is clamped to MODULUS-1.
  - done <= 0.
  - load overrides a simultaneous enable; no decrement occurs that cycle.
- Count (enable = 1, load = 0):
  - q_bus > 0: q_bus <= q_bus - 1.
  - q_bus == 0, WRAP = 1: q_bus <= MODULUS-1.
  - q_bus == 0, WRAP = 0: q_bus holds at 0.
- Hold (enable = 0, load = 0): q_bus unchanged.
- borrow_out = enable & zero & ~load & (WRAP == 1). It is always 0 in one-shot mode.
- done is set to 1 for exactly one cycle after a count takes q_bus from 1 to 0, in either mode. It is not set when 0 is reached by load or by reset, and not set for a WRAP = 1 transition from 0 to MODULUS-1.
- q_bus never leaves 0..MODULUS-1 after reset, so no illegal states are reachable.
- Decrement and wrap arithmetic is WIDTH bits unsigned. MODULUS-1 is computed at elaboration time.

## Timing

- Load-to-output latency: 1 clock (q_bus reflects load_value after the edge at which load = 1).
- Count latency: 1 clock per enabled edge. Cascaded digits share clock and advance on the same edge.
- zero and borrow_out are combinational with no register stage. They are valid in the same cycle as q_bus or enable change.
- done is asserted in the cycle after the 1 -> 0 edge, coincident with zero = 1, and deasserts on the following edge regardless of inputs.
- Deasserting reset mid-count: the counter resumes from 0 at the first edge after release. No done pulse is issued.
- Asserting reset mid-count clears q_bus and done immediately, without waiting for a clock edge.

## Test plan

- Reset/hold: WIDTH = 4, MODULUS = 10; assert reset = 0 mid-count at q_bus = 7 -> q_bus = 0, zero = 1, done = 0 with no clock edge. Release reset with enable = 0 for 5 cycles -> q_bus stays 0.
- Wrap with borrow: WRAP = 1; load 2, then enable = 1 for 4 cycles -> q_bus sequence 2, 1, 0, 9, 8. borrow_out = 1 only in the cycle where q_bus = 0. done pulses once, in the cycle q_bus = 0.
- One-shot: WRAP = 0, MODULUS = 60, WIDTH = 6; load 3, enable = 1 for 6 cycles -> 3, 2, 1, 0, 0, 0. done = 1 for exactly one cycle; borrow_out stays 0.
- Load priority and clamp: at q_bus = 5, load = 1 and enable = 1 with load_value = 12 (MODULUS = 10) -> q_bus = 9 next cycle, no decrement, borrow_out = 0.
- Cascade: two instances with MODULUS = 10; the low digit's borrow_out drives the high digit's enable. Start at 10 (high = 1, low = 0) and enable the low digit for 11 cycles -> 09, 08, ... 00, then 99. Check that the high digit decrements only on low-digit wraps.
- Degenerate modulus: MODULUS = 2, WIDTH = 1, WRAP = 1; continuous enable -> q_bus toggles 1, 0, 1, 0. borrow_out = 1 on every cycle where q_bus = 0.
